// File: rtl/cpu_mc_ctrl.sv
// Multicycle control FSM for the single-memory MIPS-subset CPU.
// Define CPU_CTRL_IMM_EN to decode addi/andi/ori through IMM_EXEC/IMM_WB.
module cpu_mc_ctrl #(
  parameter int unsigned ALU_W = 4
) (
  input  logic             clk,
  input  logic             rrst,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             pc_en,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_source,
  output logic [ALU_W-1:0] alu_op,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic             illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_IMM_EXEC = 4'd10,
    S_IMM_WB   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef CPU_CTRL_IMM_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
`endif

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [ALU_W-1:0] ALU_AND = ALU_W'(4'b0000);
  localparam logic [ALU_W-1:0] ALU_OR  = ALU_W'(4'b0001);
  localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(4'b0010);
  localparam logic [ALU_W-1:0] ALU_SUB = ALU_W'(4'b0110);
  localparam logic [ALU_W-1:0] ALU_SLT = ALU_W'(4'b0111);

  state_e state_q, state_d;
  logic   pc_write, pc_write_cond;

  always_ff @(posedge clk or posedge rrst) begin
    if (rrst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  // Outputs decode the current state directly (plus opcode/funct) so that
  // the DECODE-cycle illegal pulse and the async reset gating take effect
  // in the same cycle rather than one edge late.
  always_comb begin
    state_d       = S_FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    pc_source     = 2'd0;
    alu_op        = ALU_AND;
    instr_done    = 1'b0;
    illegal       = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (run) begin
          mem_read  = 1'b1;
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = 2'd1;
          alu_op    = ALU_ADD;
          state_d   = S_DECODE;
        end else begin
          state_d   = S_FETCH;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'd3;
        alu_op    = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef CPU_CTRL_IMM_EN
          OP_ADDI, OP_ANDI, OP_ORI: state_d = S_IMM_EXEC;
`endif
          default: begin
            illegal    = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_op    = ALU_ADD;
        state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        state_d  = S_MEM_WB;
      end
      S_MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        iord       = 1'b1;
        mem_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        state_d   = S_R_WB;
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: alu_op = ALU_ADD;
        endcase
      end
      S_R_WB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 2'd1;
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'd2;
        instr_done = 1'b1;
      end
`ifdef CPU_CTRL_IMM_EN
      S_IMM_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = S_IMM_WB;
        case (opcode)
          OP_ANDI: alu_op = ALU_AND;
          OP_ORI:  alu_op = ALU_OR;
          default: alu_op = ALU_ADD;
        endcase
      end
      S_IMM_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
`endif
      default: state_d = S_FETCH;
    endcase

    if (rrst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'd0;
      pc_source     = 2'd0;
      alu_op        = '0;
      instr_done    = 1'b0;
      illegal       = 1'b0;
    end
  end

  assign pc_en = pc_write | (pc_write_cond & zero);
  assign state = state_q;

endmodule

// File: tb/tb_cpu_mc_ctrl.sv
// Directed self-checking bench for cpu_mc_ctrl; expectations are hand-derived
// per instruction class, with an addi variant selected by CPU_CTRL_IMM_EN.
module tb_cpu_mc_ctrl;

  logic       clk = 1'b0;
  logic       rrst, run, zero;
  logic [5:0] opcode, funct;
  logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst;
  logic       mem_to_reg, reg_write, alu_src_a, instr_done, illegal;
  logic [1:0] alu_src_b, pc_source;
  logic [3:0] alu_op, state;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] snap [8];

  cpu_mc_ctrl #(.ALU_W(4)) dut (
    .clk(clk), .rrst(rrst), .run(run), .opcode(opcode), .funct(funct),
    .zero(zero), .pc_en(pc_en), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_source(pc_source), .alu_op(alu_op),
    .state(state), .instr_done(instr_done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bit map: 18 pc_en,17 iord,16 mem_read,15 mem_write,14 ir_write,13 reg_dst,
  // 12 mem_to_reg,11 reg_write,10 src_a,9:8 src_b,7:6 pc_source,5:2 alu_op,1 done,0 illegal
  function automatic logic [31:0] outs();
    return {13'd0, pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
            reg_write, alu_src_a, alu_src_b, pc_source, alu_op, instr_done, illegal};
  endfunction

  // Entered just after a rising edge with the FSM in FETCH; run is dropped
  // after the first edge to show it cannot abort an instruction.
  task automatic do_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                          input logic z, input int n, input logic [31:0] seq);
    run = 1'b1; opcode = op; funct = fn; zero = z;
    for (int i = 0; i < n; i++) begin
      #1;
      snap[i] = outs();
      check({name, "_state"}, {28'd0, state}, {28'd0, seq[4*i +: 4]});
      check({name, "_done"}, {31'd0, instr_done}, {31'd0, (i == n - 1)});
      @(posedge clk); #1;
      run = 1'b0;
    end
    #1;
    check({name, "_ret"}, {28'd0, state}, 32'd0);
  endtask

  logic [5:0] fn_tab [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [3:0] op_tab [5] = '{4'b0010,   4'b0110,   4'b0000,   4'b0001,   4'b0111};

  initial begin
    rrst = 1'b1; run = 1'b1; zero = 1'b0; opcode = '0; funct = '0;
    #1;
    check("rst_state", {28'd0, state}, 32'd0);
    check("rst_outs", outs(), 32'd0);
    @(posedge clk); #1;
    check("rst_hold", {28'd0, state}, 32'd0);
    @(negedge clk);
    rrst = 1'b0; run = 1'b0;
    @(posedge clk); #1;

    do_instr("lw", 6'b100011, 6'd0, 1'b0, 5, 32'h0004_3210);
    check("lw_fetch_mrd", {31'd0, snap[0][16]}, 32'd1);
    check("lw_fetch_irw", {31'd0, snap[0][14]}, 32'd1);
    check("lw_fetch_pcen", {31'd0, snap[0][18]}, 32'd1);
    check("lw_fetch_srcb", {30'd0, snap[0][9:8]}, 32'd1);
    check("lw_dec_srcb", {30'd0, snap[1][9:8]}, 32'd3);
    check("lw_addr_srcb", {30'd0, snap[2][9:8]}, 32'd2);
    check("lw_rd_iord", {31'd0, snap[3][17]}, 32'd1);
    check("lw_rd_mrd", {31'd0, snap[3][16]}, 32'd1);
    check("lw_wb_regw", {31'd0, snap[4][11]}, 32'd1);
    check("lw_wb_m2r", {31'd0, snap[4][12]}, 32'd1);

    do_instr("sw", 6'b101011, 6'd0, 1'b0, 4, 32'h0000_5210);
    check("sw_wr_memw", {31'd0, snap[3][15]}, 32'd1);
    check("sw_wr_iord", {31'd0, snap[3][17]}, 32'd1);
    check("sw_wr_regw", {31'd0, snap[3][11]}, 32'd0);

    do_instr("sub", 6'b000000, 6'b100010, 1'b0, 4, 32'h0000_7610);
    check("sub_aluop", {28'd0, snap[2][5:2]}, 32'h6);
    check("sub_srca", {31'd0, snap[2][10]}, 32'd1);
    check("sub_regdst", {31'd0, snap[3][13]}, 32'd1);
    check("sub_regw", {31'd0, snap[3][11]}, 32'd1);

    for (int k = 0; k < 5; k++) begin
      do_instr("rtab", 6'b000000, fn_tab[k], 1'b0, 4, 32'h0000_7610);
      check("rtab_aluop", {28'd0, snap[2][5:2]}, {28'd0, op_tab[k]});
    end
    do_instr("rbad", 6'b000000, 6'b111111, 1'b0, 4, 32'h0000_7610);
    check("rbad_aluop", {28'd0, snap[2][5:2]}, 32'h2);

    do_instr("beq1", 6'b000100, 6'd0, 1'b1, 3, 32'h0000_0810);
    check("beq1_pcen", {31'd0, snap[2][18]}, 32'd1);
    check("beq1_pcsrc", {30'd0, snap[2][7:6]}, 32'd1);
    check("beq1_aluop", {28'd0, snap[2][5:2]}, 32'h6);
    do_instr("beq0", 6'b000100, 6'd0, 1'b0, 3, 32'h0000_0810);
    check("beq0_pcen", {31'd0, snap[2][18]}, 32'd0);

    do_instr("j", 6'b000010, 6'd0, 1'b0, 3, 32'h0000_0910);
    check("j_pcen", {31'd0, snap[2][18]}, 32'd1);
    check("j_pcsrc", {30'd0, snap[2][7:6]}, 32'd2);

    do_instr("ill", 6'b111111, 6'd0, 1'b0, 2, 32'h0000_0010);
    check("ill_pulse", {31'd0, snap[1][0]}, 32'd1);
    check("ill_fetch", {31'd0, snap[0][0]}, 32'd0);

    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("idle_state", {28'd0, state}, 32'd0);
      check("idle_en", {25'd0, pc_en, mem_read, mem_write, ir_write, reg_write,
                        instr_done, illegal}, 32'd0);
    end

`ifdef CPU_CTRL_IMM_EN
    do_instr("addi", 6'b001000, 6'd0, 1'b0, 4, 32'h0000_BA10);
    check("addi_aluop", {28'd0, snap[2][5:2]}, 32'h2);
    check("addi_srcb", {30'd0, snap[2][9:8]}, 32'd2);
    check("addi_regdst", {31'd0, snap[3][13]}, 32'd0);
    check("addi_regw", {31'd0, snap[3][11]}, 32'd1);
    do_instr("ori", 6'b001101, 6'd0, 1'b0, 4, 32'h0000_BA10);
    check("ori_aluop", {28'd0, snap[2][5:2]}, 32'h1);
`else
    do_instr("addi", 6'b001000, 6'd0, 1'b0, 2, 32'h0000_0010);
    check("addi_ill", {31'd0, snap[1][0]}, 32'd1);
`endif

    // Async reset in the middle of MEM_RD, away from any clock edge.
    run = 1'b1; opcode = 6'b100011;
    repeat (3) @(posedge clk);
    #2;
    check("mid_state", {28'd0, state}, 32'd3);
    check("mid_mrd", {31'd0, mem_read}, 32'd1);
    rrst = 1'b1;
    #1;
    check("arst_state", {28'd0, state}, 32'd0);
    check("arst_mrd", {31'd0, mem_read}, 32'd0);
    check("arst_outs", outs(), 32'd0);
    @(negedge clk);
    rrst = 1'b0;
    @(posedge clk); #1;
    check("rel_state", {28'd0, state}, 32'd1);
    run = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rel_ret", {28'd0, state}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_mc_ctrl.md
# cpu_mc_ctrl

Multicycle control unit for the single-memory MIPS-subset CPU inside `cpu_top`. A registered state machine sequences each instruction through fetch, decode, execute, memory and write-back. It drives every enable and mux-select of the shared datapath: PC, IR, memory, register file and ALU. It also produces a per-instruction completion pulse, which the display path uses to step through execution.

## Interface
Parameters:
- `ALU_W`, 4, width of the ALU operation code.

Ports:
- `clk`  in  1  system clock; all state changes happen on the rising edge.
- `rrst`  in  1  reset, asynchronous and active-high.
- `run`  in  1  start the next instruction; sampled only in FETCH.
- `opcode`  in  6  IR[31:26]; valid from DECODE onward.
- `funct`  in  6  IR[5:0].
- `zero`  in  1  ALU zero flag.
- `pc_en`  out  1  PC load enable, equal to `pc_write | (pc_write_cond & zero)`.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `mem_read`  out  1  memory read.
- `mem_write`  out  1  memory write.
- `ir_write`  out  1  IR load enable.
- `reg_dst`  out  1  destination register select: 0 = rt, 1 = rd.
- `mem_to_reg`  out  1  write-back data select: 0 = ALUOut, 1 = MDR.
- `reg_write`  out  1  register file write enable.
- `alu_src_a`  out  1  ALU A select: 0 = PC, 1 = A register.
- `alu_src_b`  out  2  ALU B select: 0 = B register, 1 = constant 4, 2 = sign-extended immediate, 3 = shifted sign-extended immediate.
- `pc_source`  out  2  next-PC select: 0 = ALU, 1 = ALUOut, 2 = jump target.
- `alu_op`  out  `ALU_W`  ALU operation: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111.
- `state`  out  4  current state, for debug and display.
- `instr_done`  out  1  one-cycle pulse in the last cycle of each instruction.
- `illegal`  out  1  one-cycle pulse in DECODE when the opcode is not supported.

## Operation
- State encoding: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXEC 6, R_WB 7, BRANCH 8, JUMP 9, IMM_EXEC 10, IMM_WB 11. Codes 12–15 are unused and go to FETCH on the next edge.
- FETCH with `run`=1:
  - asserts mem_read, ir_write, pc_write; iord=0, src_a=0, src_b=1, ADD, pc_source=0.
  - next state is DECODE.
- FETCH with `run`=0: all enables are 0 and the FSM stays in FETCH.
- DECODE: src_a=0, src_b=3, ADD (precomputes the branch target). Next state by opcode:
  - 100011 (lw) and 101011 (sw) → MEM_ADDR.
  - 000000 (R-type) → EXEC.
  - 000100 (beq) → BRANCH.
  - 000010 (j) → JUMP.
  - 001000 / 001100 / 001101 (addi / andi / ori) → IMM_EXEC, but only when the immediate feature is compiled in.
  - any other opcode → FETCH, with `illegal`=1 and `instr_done`=1.
- MEM_ADDR: src_a=1, src_b=2, ADD. Next state is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: iord=1, mem_read. Next state is MEM_WB.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_write, done.
- MEM_WR: iord=1, mem_write, done.
- EXEC: src_a=1, src_b=0. alu_op comes from funct:
  - 100000 → ADD, 100010 → SUB, 100100 → AND, 100101 → OR, 101010 → SLT.
  - any other funct → ADD.
- R_WB: reg_dst=1, mem_to_reg=0, reg_write, done.
- BRANCH: src_a=1, src_b=0, SUB, pc_write_cond, pc_source=1, done.
- JUMP: pc_write, pc_source=2, done.
- IMM_EXEC: src_a=1, src_b=2. alu_op is ADD for addi, AND for andi, OR for ori.
- IMM_WB: reg_dst=0, mem_to_reg=0, reg_write, done.
- Every "done" state returns to FETCH. Any output not listed for a state is 0.

## Timing
- Outputs are Moore functions of `state` plus `opcode`/`funct`; `pc_en` additionally depends combinationally on `zero`.
- Cycles per instruction, counted from the FETCH cycle with `run`=1:
  - lw 5; sw 4; R-type 4; immediate 4; beq 3; j 3; illegal opcode 2.
- `instr_done` is high exactly one cycle per instruction, in its last cycle.
- `run` is ignored outside FETCH. Dropping `run` mid-instruction does not abort the instruction.
- Reset, including assertion mid-instruction: the state goes to FETCH immediately, without waiting for a clock edge. While `rrst`=1, every enable, `instr_done` and `illegal` are forced to 0 and all selects read 0. The first fetch happens on the first rising edge after `rrst` falls with `run`=1.

## Configuration
- `CPU_CTRL_IMM_EN` defined: addi, andi and ori are decoded, and IMM_EXEC and IMM_WB exist.
- `CPU_CTRL_IMM_EN` not defined: opcodes 001000, 001100 and 001101 are treated as illegal, and states 10/11 are unreachable and go to FETCH if entered.

## Test plan
- Reset: assert `rrst` mid-MEM_RD with no clock edge → `state`=0 immediately and `mem_read`=0; release with `run`=1 → DECODE after one edge.
- lw (opcode 100011): states 0→1→2→3→4→0. Required: `iord`=1 in state 3; `reg_write`=1 with `mem_to_reg`=1 in state 4; `instr_done` high only in state 4.
- R-type sub (funct 100010): `alu_op`=0110 in EXEC; `reg_dst`=1 with `reg_write` in R_WB; 4 cycles total.
- beq: with `zero`=1 → `pc_en`=1 and `pc_source`=1 in BRANCH; with `zero`=0 → `pc_en`=0; both take 3 cycles.
- Opcode 111111: `illegal`=1 and `instr_done`=1 in DECODE, then FETCH. With `run`=0 the FSM holds in FETCH for 10 cycles with all enables 0.
- addi (opcode 001000):
  - with `CPU_CTRL_IMM_EN` → states 0→1→10→11→0, `alu_op`=0010, `reg_dst`=0;
  - without it → the illegal pulse occurs instead.
